// File: rtl/neuron_pu.sv
// Sign-magnitude dot-product neuron: LANES multipliers per beat, saturating
// accumulator, bias add, arithmetic shift and optional ReLU.
module neuron_pu #(
  parameter int DW    = 8,
  parameter int LANES = 8,
  parameter int ACC_W = 24,
  parameter int SHIFT = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LANES*DW-1:0] x,
  input  logic [LANES*DW-1:0] w,
  input  logic [DW-1:0]       bias,
  input  logic                act_en,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [DW-1:0]       out,
  output logic                ovf,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int MAG_W  = DW - 1;
  localparam int PROD_W = 2 * MAG_W + 1;
  localparam int SUM_W  = PROD_W + $clog2(LANES) + 1;
  localparam int WIDE_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 2 * DW + 2;

  localparam logic signed [WIDE_W-1:0] ACC_MAX    = WIDE_W'((longint'(1) << (ACC_W - 1)) - 1);
  localparam logic signed [WIDE_W-1:0] ACC_MIN    = ~ACC_MAX;
  localparam logic signed [WIDE_W-1:0] BIAS_SCALE = WIDE_W'((1 << (DW - 1)) - 1);
  localparam logic signed [ACC_W:0]    OUT_MAX    = (ACC_W + 1)'((1 << (DW - 1)) - 1);

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN1, DRAIN2, OUT} state_t;

  state_t state, state_nxt;

  // Negative zero maps naturally to 0 because -0 == 0.
  function automatic logic signed [DW-1:0] sm2tc(input logic [DW-1:0] v);
    logic signed [DW-1:0] m;
    m = $signed({1'b0, v[DW-2:0]});
    return v[DW-1] ? -m : m;
  endfunction

  function automatic logic signed [PROD_W-1:0] lane_prod(input logic [DW-1:0] a,
                                                         input logic [DW-1:0] b);
    logic [2*MAG_W-1:0]        m;
    logic signed [PROD_W-1:0]  p;
    m = (2*MAG_W)'(a[DW-2:0]) * (2*MAG_W)'(b[DW-2:0]);
    p = $signed({1'b0, m});
    return (a[DW-1] ^ b[DW-1]) ? -p : p;
  endfunction

  function automatic logic sat_hit(input logic signed [WIDE_W-1:0] v);
    return (v > ACC_MAX) || (v < ACC_MIN);
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [WIDE_W-1:0] v);
    logic signed [WIDE_W-1:0] c;
    c = v;
    if (v > ACC_MAX) c = ACC_MAX;
    else if (v < ACC_MIN) c = ACC_MIN;
    return c[ACC_W-1:0];
  endfunction

  function automatic logic [DW-1:0] act_out(input logic signed [ACC_W-1:0] r,
                                            input logic relu);
    logic signed [ACC_W:0] mag;
    logic                  neg;
    neg = r[ACC_W-1];
    mag = (ACC_W + 1)'(r);
    if (neg) mag = -mag;
    if (mag > OUT_MAX) mag = OUT_MAX;
    if (neg && relu) return '0;
    return {neg, mag[DW-2:0]};
  endfunction

  logic                     accept;
  logic                     vld_p0, first_p0, act_en_p0;
  logic signed [PROD_W-1:0] prod_p0 [LANES];
  logic [DW-1:0]            bias_p0;
  logic signed [SUM_W-1:0]  sum_p0;
  logic signed [WIDE_W-1:0] acc_base, acc_wide, res_wide;
  logic signed [ACC_W-1:0]  acc_p1, res_sh;
  logic                     ovf_p1;
  logic [DW-1:0]            out_p2;
  logic                     ovf_p2, vld_p2;

  assign in_ready  = rst && ((state == IDLE) || (state == ACCUM));
  assign accept    = in_valid && in_ready;
  assign out       = out_p2;
  assign ovf       = ovf_p2;
  assign out_valid = vld_p2;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: if (accept) state_nxt = in_last ? DRAIN1 : ACCUM;
      DRAIN1:      state_nxt = DRAIN2;
      DRAIN2:      state_nxt = OUT;
      OUT:         if (out_ready) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // Stage p0: per-lane signed products captured on the accepting edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_p0[i] <= '0;
    end else begin
      vld_p0 <= accept;
      if (accept) begin
        first_p0 <= (state == IDLE);
        for (int i = 0; i < LANES; i++) prod_p0[i] <= lane_prod(x[DW*i +: DW], w[DW*i +: DW]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && in_last) begin
      bias_p0   <= bias;
      act_en_p0 <= act_en;
    end
  end

  always_comb begin
    sum_p0 = '0;
    for (int i = 0; i < LANES; i++) sum_p0 = sum_p0 + SUM_W'(prod_p0[i]);
    acc_base = WIDE_W'(acc_p1);
    if (first_p0) acc_base = '0;
    acc_wide = acc_base + WIDE_W'(sum_p0);
  end

  // Stage p1: saturating accumulator with sticky overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_p1 <= '0;
      ovf_p1 <= 1'b0;
    end else if (vld_p0) begin
      acc_p1 <= sat_acc(acc_wide);
      ovf_p1 <= (ovf_p1 && !first_p0) || sat_hit(acc_wide);
    end
  end

  always_comb begin
    res_wide = WIDE_W'(acc_p1) + WIDE_W'(sm2tc(bias_p0)) * BIAS_SCALE;
    res_sh   = sat_acc(res_wide) >>> SHIFT;
  end

  // Stage p2: biased, shifted, activated result held until taken
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_p2 <= '0;
      ovf_p2 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (state == DRAIN2) begin
      out_p2 <= act_out(res_sh, act_en_p0);
      ovf_p2 <= ovf_p1;
      vld_p2 <= 1'b1;
    end else if ((state == OUT) && out_ready) begin
      vld_p2 <= 1'b0;
    end
  end

endmodule
